// File: rtl/alu_seq_unit.sv
// Multi-cycle MIPS ALU: single-cycle arithmetic/logic/compare/lui, bit-serial shifts and clz,
// with valid/ready handshakes on both the request and the result side.
module alu_seq_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  aluc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry,
    output logic        negative,
    output logic        overflow
);
    localparam logic [4:0] OP_ADDU = 5'b00000, OP_SUBU = 5'b00001, OP_ADD  = 5'b00010,
                           OP_SUB  = 5'b00011, OP_AND  = 5'b00100, OP_OR   = 5'b00101,
                           OP_XOR  = 5'b00110, OP_NOR  = 5'b00111, OP_SLT  = 5'b01011,
                           OP_SLTU = 5'b01010, OP_SLL  = 5'b01111, OP_SRL  = 5'b01101,
                           OP_SRA  = 5'b01100, OP_LUI  = 5'b01000, OP_CLZ  = 5'b10000,
                           OP_BGEZ = 5'b10001;

    typedef enum logic [1:0] {IDLE, SHIFT, CLZ, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  op;
    logic [31:0] work;
    logic [5:0]  cnt;

    logic        is_shift, is_clz;
    logic [32:0] sum33, diff33;
    logic [31:0] alu_res;
    logic        alu_c, alu_v;

    assign is_shift = (aluc == OP_SLL) || (aluc == OP_SRL) || (aluc == OP_SRA);
    assign is_clz   = (aluc == OP_CLZ);

    // Single-cycle datapath, evaluated on the live operands at acceptance.
    always_comb begin
        sum33   = {1'b0, a} + {1'b0, b};
        diff33  = {1'b0, a} - {1'b0, b};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluc)
            OP_ADDU: begin alu_res = sum33[31:0];  alu_c = sum33[32];  end
            OP_SUBU: begin alu_res = diff33[31:0]; alu_c = diff33[32]; end
            OP_ADD: begin
                alu_res = sum33[31:0];
                alu_c   = sum33[32];
                alu_v   = (a[31] == b[31]) && (sum33[31] != a[31]);
            end
            OP_SUB: begin
                alu_res = diff33[31:0];
                alu_c   = diff33[32];
                alu_v   = (a[31] != b[31]) && (diff33[31] != a[31]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {31'b0, a < b};
            OP_LUI:  alu_res = {b[15:0], 16'h0};
            OP_BGEZ: alu_res = {31'b0, ~a[31]};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_valid) state_nxt = is_shift ? SHIFT : (is_clz ? CLZ : DONE);
            SHIFT: if (cnt == 6'd0) state_nxt = DONE;
            CLZ:   if (work[31] || cnt == 6'd32) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result and flags are only written on the transition into DONE, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= '0;
            work     <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op <= aluc;
                    if (is_shift) begin
                        work <= b;
                        cnt  <= {1'b0, a[4:0]};
                    end else if (is_clz) begin
                        work <= a;
                        cnt  <= '0;
                    end else begin
                        result   <= alu_res;
                        zero     <= (alu_res == 32'd0);
                        negative <= alu_res[31];
                        carry    <= alu_c;
                        overflow <= alu_v;
                    end
                end
                SHIFT: begin
                    if (cnt == 6'd0) begin
                        result   <= work;
                        zero     <= (work == 32'd0);
                        negative <= work[31];
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end else begin
                        case (op)
                            OP_SLL:  work <= {work[30:0], 1'b0};
                            OP_SRA:  work <= {work[31], work[31:1]};
                            default: work <= {1'b0, work[31:1]};
                        endcase
                        cnt <= cnt - 6'd1;
                    end
                end
                CLZ: begin
                    if (work[31] || cnt == 6'd32) begin
                        result   <= {26'b0, cnt};
                        zero     <= (cnt == 6'd0);
                        negative <= 1'b0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                    end else begin
                        work <= {work[30:0], 1'b0};
                        cnt  <= cnt + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: behavioural reference model, directed literal cases,
// randomized ops with random backpressure, and a mid-operation reset.
module tb_alu_seq_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  aluc;
    logic [31:0] a, b, result;
    logic        zero, carry, negative, overflow;

    int n_chk = 0, n_fail = 0;

    logic [31:0] exp_res;
    logic        exp_z, exp_c, exp_n, exp_v;
    int          exp_lat;
    logic        mon_en = 1'b0;

    alu_seq_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluc(aluc), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model straight from the operation table, using wide integer arithmetic.
    task automatic model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic c, output logic v, output int lat);
        longint sx, sy, s;
        int      sh, lz;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(x[4:0]);
        r = 0; c = 0; v = 0; lat = 1;
        case (op)
            5'b00000, 5'b00010: begin
                r = x + y;
                c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
                s = sx + sy;
                if (op == 5'b00010) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'b00001, 5'b00011: begin
                r = x - y;
                c = x < y;
                s = sx - sy;
                if (op == 5'b00011) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'b00100: r = x & y;
            5'b00101: r = x | y;
            5'b00110: r = x ^ y;
            5'b00111: r = ~(x | y);
            5'b01011: r = (sx < sy) ? 1 : 0;
            5'b01010: r = (x < y) ? 1 : 0;
            5'b01111: begin r = y << sh; lat = 2 + sh; end
            5'b01101: begin r = y >> sh; lat = 2 + sh; end
            5'b01100: begin r = $signed(y) >>> sh; lat = 2 + sh; end
            5'b01000: r = {y[15:0], 16'h0};
            5'b10000: begin
                lz = 0;
                while (lz < 32 && x[31-lz] == 1'b0) lz++;
                r = lz;
                lat = 2 + lz;
            end
            5'b10001: r = (sx >= 0) ? 1 : 0;
            default: r = 0;
        endcase
    endtask

    // Compare process: every cycle the result is presented, it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid && mon_en) begin
            chk("result", result, exp_res);
            chk("zero", {31'b0, zero}, {31'b0, exp_z});
            chk("carry", {31'b0, carry}, {31'b0, exp_c});
            chk("negative", {31'b0, negative}, {31'b0, exp_n});
            chk("overflow", {31'b0, overflow}, {31'b0, exp_v});
            chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int hold, output int lat);
        logic [31:0] r;
        logic        c, v;
        int          el;
        model(op, x, y, r, c, v, el);
        exp_res = r; exp_c = c; exp_v = v; exp_z = (r == 0); exp_n = r[31]; exp_lat = el;
        mon_en = 1'b1;
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; aluc = op; a = x; b = y; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, el);
        // Backpressure: DONE must hold, and fresh requests must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; aluc = 5'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        mon_en = 1'b0;
        chk("consumed_valid", {31'b0, out_valid}, 32'd0);
        chk("consumed_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_lit(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] lit_res, input int lit_lat, input int hold);
        int lat;
        logic [31:0] seen;
        fork
            begin
                @(posedge out_valid);
                #1 seen = result;
            end
            run_op(op, x, y, hold, lat);
        join
        chk("lit_result", seen, lit_res);
        chk("lit_latency", lat, lit_lat);
    endtask

    logic [4:0] codes [0:17];

    initial begin
        int lat;
        codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
                  5'b00111, 5'b01011, 5'b01010, 5'b01111, 5'b01101, 5'b01100, 5'b01000,
                  5'b10000, 5'b10001, 5'b11111, 5'b10010};
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; aluc = '0; a = '0; b = '0;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'b0, zero, carry, negative, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-computed results.
        run_lit(5'b00010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1, 0);
        chk("add_flags_ovnc", {28'b0, zero, carry, negative, overflow}, {28'b0, 4'b0011});
        run_lit(5'b00001, 32'd0, 32'd1, 32'hFFFFFFFF, 1, 0);
        chk("subu_flags", {28'b0, zero, carry, negative, overflow}, {28'b0, 4'b0110});
        run_lit(5'b00011, 32'd5, 32'd5, 32'd0, 1, 0);
        chk("sub_zero", {31'b0, zero}, 32'd1);
        run_lit(5'b01100, 32'd31, 32'h80000000, 32'hFFFFFFFF, 33, 0);
        run_lit(5'b01111, 32'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 2, 0);
        run_lit(5'b10000, 32'd0, 32'd0, 32'd32, 34, 0);
        run_lit(5'b10000, 32'h00010000, 32'd0, 32'd15, 17, 0);
        run_lit(5'b10000, 32'h80000000, 32'd0, 32'd0, 2, 0);
        run_lit(5'b00110, 32'hF0F0_1234, 32'h0FF0_4321, 32'hFF00_5115, 1, 10);
        run_lit(5'b01011, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 0);
        run_lit(5'b01010, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0);
        run_lit(5'b01000, 32'd0, 32'h1234, 32'h12340000, 1, 0);
        run_lit(5'b10001, 32'hFFFFFFFC, 32'd0, 32'd0, 1, 0);
        run_lit(5'b00111, 32'd0, 32'd0, 32'hFFFFFFFF, 1, 0);
        run_lit(5'b01101, 32'd4, 32'h8000_00F0, 32'h0800_000F, 6, 0);
        run_lit(5'b11111, 32'h1234, 32'h5678, 32'd0, 1, 0);
        chk("unknown_flags", {28'b0, zero, carry, negative, overflow}, {28'b0, 4'b1000});

        // Reset in the middle of a 20-cycle shift.
        @(negedge clk);
        in_valid = 1'b1; aluc = 5'b01111; a = 32'd20; b = 32'hDEAD_BEEF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", {31'b0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            chk("post_abort_idle", {30'b0, in_ready, out_valid}, 32'd2);
        end

        // Randomized ops with random backpressure.
        for (int k = 0; k < 150; k++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                0: x = x >> $urandom_range(0, 31);
                1: y = x;
                default: ;
            endcase
            run_op(codes[$urandom_range(0, 17)], x, y, $urandom_range(0, 3), lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
